vreg_store_serializer: RTL

//   Read-side client of the 8x256-bit vector Register_File. Accepts a store command naming one

---
 rtl/vreg_store_serializer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/vreg_store_serializer.sv
// rtl/vreg_store_serializer.sv - streams one vector register out as narrow valid/ready beats
//
// Purpose: read-side client of the vector register file. A store command names a
// register; the block reads it through the file's combinational read port, snapshots
// it into a shift register and emits REG_WIDTH/BEAT_WIDTH beats, least-significant first.
//
// Optional feature macro: VSTORE_PARITY_EN (adds out_par = ^out_data).
//
// Ports:
//   clk, rst    clock (rising edge) and asynchronous active-high reset
//   cmd_valid   store command request
//   cmd_ready   command accepted when cmd_valid && cmd_ready (high only in IDLE)
//   cmd_addr    register index to store
//   cmd_err     one-cycle pulse after accepting an out-of-range cmd_addr
//   busy        high in any state except IDLE
//   rf_a1       register file read address (A1)
//   rf_rd1      register file read data (RD1), combinational in rf_a1
//   out_valid   beat valid
//   out_ready   sink ready
//   out_data    beat data
//   out_last    final beat marker
//   out_par     even parity of out_data (VSTORE_PARITY_EN only)
module vreg_store_serializer #(
  parameter int NUM_REGS   = 8,
  parameter int REG_WIDTH  = 256,
  parameter int BEAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [4:0]            cmd_addr,
  output logic                  cmd_err,
  output logic                  busy,
  output logic [4:0]            rf_a1,
  input  logic [REG_WIDTH-1:0]  rf_rd1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BEAT_WIDTH-1:0] out_data,
  output logic                  out_last
`ifdef VSTORE_PARITY_EN
  ,
  output logic                  out_par
`endif
);

  localparam int NUM_BEATS = REG_WIDTH / BEAT_WIDTH;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NUM_BEATS - 1);
  localparam logic [5:0]       NUM_REGS_W = 6'(NUM_REGS);
  localparam logic             ONE_BEAT   = (NUM_BEATS == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   cmd_ready_q;
  logic                   cmd_err_q;
  logic [4:0]             addr_q;
  logic                   out_valid_q;
  logic                   out_last_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [REG_WIDTH-1:0]   shift_q;

  logic                   accept_d;
  logic                   addr_ok_d;
  logic [CNT_W-1:0]       cnt_d;

  assign accept_d  = cmd_valid && cmd_ready_q;
  assign addr_ok_d = ({1'b0, cmd_addr} < NUM_REGS_W);
  assign cnt_d     = cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
    end else begin
      cmd_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept_d) begin
            // addr_q also drives rf_a1, so RD1 is valid throughout READ.
            addr_q <= cmd_addr;
            if (addr_ok_d) begin
              state_q     <= READ;
              cmd_ready_q <= 1'b0;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
        end
        READ: begin
          // Snapshot: later writes to this register do not disturb the stream.
          shift_q     <= rf_rd1;
          cnt_q       <= '0;
          out_valid_q <= 1'b1;
          out_last_q  <= ONE_BEAT;
          state_q     <= SEND;
        end
        SEND: begin
          // Nothing moves while out_ready is low, keeping the beat stable.
          if (out_ready) begin
            shift_q <= shift_q >> BEAT_WIDTH;
            if (out_last_q) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              cnt_q       <= '0;
              cmd_ready_q <= 1'b1;
            end else begin
              cnt_q      <= cnt_d;
              out_last_q <= (cnt_d == LAST_CNT);
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign cmd_err   = cmd_err_q;
  assign busy      = (state_q != IDLE);
  assign rf_a1     = addr_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = shift_q[BEAT_WIDTH-1:0];

`ifdef VSTORE_PARITY_EN
  assign out_par = ^out_data;
`endif

endmodule
